serial_adder: RTL

- Parametrised multi-cycle adder/subtractor built from a DIGIT-bit full-adder slice.
- Processes operands LSB-first, DIGIT bits per clock.
- Adds a start/busy/done handshake, a subtract mode and a registered result.
- Serves as the area-lean arithmetic unit for datapaths where WIDTH-bit ripple logic per cycle is not affordable.

---
 rtl/serial_adder_if.sv | 25 ++
 rtl/serial_adder.sv | 117 +++++++++++
 2 files changed

// File: rtl/serial_adder_if.sv
// Start/operand/result bundle for serial_adder.
// With SERIAL_ADDER_OVF_EN defined the bundle also carries the signed-overflow flag ovf.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             cout;
    logic [WIDTH-1:0] sum;

`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;

    modport master (output start, sub, cin, a, b, input busy, done, cout, sum, ovf);
    modport slave  (input start, sub, cin, a, b, output busy, done, cout, sum, ovf);
`else
    modport master (output start, sub, cin, a, b, input busy, done, cout, sum);
    modport slave  (input start, sub, cin, a, b, output busy, done, cout, sum);
`endif
endinterface

// File: rtl/serial_adder.sv
// LSB-first multi-cycle adder/subtractor, DIGIT bits per clock, WIDTH/DIGIT cycles per operation.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_adder: WIDTH must be a positive multiple of DIGIT");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             busy_r;
    logic             done_r;

    function automatic logic [DIGIT:0] slice_add(input logic [DIGIT-1:0] x,
                                                 input logic [DIGIT-1:0] y,
                                                 input logic             c);
        return {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, c};
    endfunction

    logic [DIGIT:0]   slice;
    logic [WIDTH-1:0] acc_next;

    assign slice    = slice_add(opa[DIGIT-1:0], opb[DIGIT-1:0], carry);
    // New digit enters at the top so the LSB digit ends up at bit 0 after N steps.
    assign acc_next = WIDTH'({slice[DIGIT-1:0], acc} >> DIGIT);

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_r;
    logic ovf_slice;

    // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
    assign ovf_slice = slice[DIGIT] ^ slice[DIGIT-1] ^ opa[DIGIT-1] ^ opb[DIGIT-1];
    assign bus.ovf   = ovf_r;
`endif

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            opa    <= '0;
            opb    <= '0;
            acc    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_r  <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    // Subtraction is a + ~b + ~borrow_in, so cout=1 means no borrow.
                    if (bus.start) begin
                        opa    <= bus.a;
                        opb    <= bus.sub ? ~bus.b : bus.b;
                        carry  <= bus.sub ? ~bus.cin : bus.cin;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    opa   <= opa >> DIGIT;
                    opb   <= opb >> DIGIT;
                    acc   <= acc_next;
                    carry <= slice[DIGIT];
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum_r  <= acc_next;
                        cout_r <= slice[DIGIT];
`ifdef SERIAL_ADDER_OVF_EN
                        ovf_r  <= ovf_slice;
`endif
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
